// File: rtl/pkt_comm_pkg.sv
// pkt_comm_pkg: shared word/checksum widths, packet FSM encoding and the `MSB width helper.
`ifndef PKT_COMM_MSB_DEFINED
`define PKT_COMM_MSB_DEFINED
`define MSB(x) (($clog2((x) + 1) > 0) ? $clog2((x) + 1) - 1 : 0)
`endif

package pkt_comm_pkg;
    localparam int WORD_WIDTH = 16;
    localparam int CSUM_WIDTH = 32;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DATA    = 2'd1;
    localparam logic [1:0] CSUM_LO = 2'd2;
    localparam logic [1:0] CSUM_HI = 2'd3;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over req, searching from ptr+1 upward (mod N).
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         hit
);
    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        // walk farthest-to-nearest so the nearest requester after ptr wins
        for (int i = N; i >= 1; i--) begin
            if (req[W'((int'(ptr) + i) % N)]) begin
                grant = N'(1) << ((int'(ptr) + i) % N);
                idx   = W'((int'(ptr) + i) % N);
                hit   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/outpkt_arbiter_csum.sv
// outpkt_arbiter_csum: packet-granular N-channel arbiter into one 16-bit FIFO, appending a 32-bit checksum trailer.
// Define OUTPKT_LEN_CHECK_EN to cut packets at MAX_PKT_WORDS data words and flag err_pkt_len.
module outpkt_arbiter_csum
    import pkt_comm_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int MAX_PKT_WORDS = 65536
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_CH*WORD_WIDTH-1:0] din,
    input  logic [N_CH-1:0]            pkt_new,
    input  logic [N_CH-1:0]            pkt_end,
    input  logic [N_CH-1:0]            empty,
    output logic [N_CH-1:0]            rd_en,
    output logic [WORD_WIDTH-1:0]      dout,
    output logic                       wr_en,
    input  logic                       full,
    output logic [`MSB(N_CH-1):0]      active_ch,
    output logic                       busy,
    output logic                       err_sync,
    output logic                       err_pkt_len
);
    localparam int AW = `MSB(N_CH-1) + 1;

    logic [1:0]            state;
    logic [AW-1:0]         ptr, arb_idx;
    logic [N_CH-1:0]       arb_req, arb_grant, gsel, sync_req, sync_sel;
    logic                  arb_hit, valid, started, odd, free;
    logic                  head_rdy, head_new, head_end, restart, pop, len_hit;
    logic [WORD_WIDTH-1:0] head, lo;
    logic [CSUM_WIDTH-1:0] sum, fsum;

    rr_arbiter #(.N(N_CH), .W(AW)) u_rr (
        .req(arb_req), .ptr(ptr), .grant(arb_grant), .idx(arb_idx), .hit(arb_hit)
    );

    assign arb_req  = ~empty & pkt_new;
    assign sync_req = ~empty & ~pkt_new;
    assign sync_sel = sync_req & (~sync_req + N_CH'(1));

    always_comb begin
        head = '0;
        for (int i = 0; i < N_CH; i++)
            head = head | (din[WORD_WIDTH*i +: WORD_WIDTH] & {WORD_WIDTH{gsel[i]}});
    end

    assign head_rdy = |(gsel & ~empty);
    assign head_new = |(gsel & pkt_new);
    assign head_end = |(gsel & pkt_end);
    assign free     = ~valid | ~full;
    // a fresh packet start after the first word closes the current packet without being consumed
    assign restart  = state == DATA && started && head_rdy && head_new;
    assign pop      = state == DATA && head_rdy && !restart && free;
    assign rd_en    = RST ? '0 : pop ? gsel : (state == IDLE && !arb_hit) ? sync_sel : '0;
    assign wr_en    = valid & ~full & ~RST;
    assign busy     = state != IDLE;
    assign fsum     = sum + {{WORD_WIDTH{1'b0}}, lo & {WORD_WIDTH{odd}}};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ptr       <= AW'(N_CH - 1);
            active_ch <= '0;
            gsel      <= '0;
            valid     <= 1'b0;
            dout      <= '0;
            sum       <= '0;
            lo        <= '0;
            odd       <= 1'b0;
            started   <= 1'b0;
            err_sync  <= 1'b0;
        end else begin
            valid <= valid & full;
            case (state)
                IDLE: begin
                    if (arb_hit) begin
                        state     <= DATA;
                        ptr       <= arb_idx;
                        active_ch <= arb_idx;
                        gsel      <= arb_grant;
                        sum       <= '0;
                        odd       <= 1'b0;
                        started   <= 1'b0;
                    end else if (|sync_req) begin
                        err_sync <= 1'b1;
                    end
                end
                DATA: begin
                    if (restart) begin
                        err_sync <= 1'b1;
                        state    <= CSUM_LO;
                    end else if (pop) begin
                        dout    <= head;
                        valid   <= 1'b1;
                        started <= 1'b1;
                        odd     <= ~odd;
                        if (odd) sum <= sum + {head, lo};
                        else lo <= head;
                        if (head_end || len_hit) state <= CSUM_LO;
                    end
                end
                CSUM_LO: begin
                    if (free) begin
                        dout  <= ~fsum[WORD_WIDTH-1:0];
                        valid <= 1'b1;
                        sum   <= fsum;
                        odd   <= 1'b0;
                        state <= CSUM_HI;
                    end
                end
                default: begin
                    if (free) begin
                        dout  <= ~sum[CSUM_WIDTH-1:WORD_WIDTH];
                        valid <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef OUTPKT_LEN_CHECK_EN
    logic [16:0] cnt;
    assign len_hit = cnt == 17'(MAX_PKT_WORDS - 1) && !head_end;
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt         <= '0;
            err_pkt_len <= 1'b0;
        end else begin
            if (state == IDLE) cnt <= '0;
            else if (pop) cnt <= cnt + 17'd1;
            if (pop && len_hit) err_pkt_len <= 1'b1;
        end
    end
`else
    assign len_hit     = 1'b0;
    assign err_pkt_len = 1'b0;
`endif
endmodule

// File: tb/tb_outpkt_arbiter_csum.sv
// tb_outpkt_arbiter_csum: FWFT channel sources with random stalls, packet/checksum reference model, RR order model.
module tb_outpkt_arbiter_csum;
    localparam int N = 4;
    typedef logic [15:0] wq_t[$];

    logic          CLK = 1'b0;
    logic          RST;
    logic [N*16-1:0] din;
    logic [N-1:0]  pkt_new, pkt_end, empty, rd_en;
    logic [15:0]   dout;
    logic          wr_en, full, busy, err_sync, err_pkt_len;
    logic [1:0]    active_ch;

    always #5 CLK = ~CLK;

    outpkt_arbiter_csum #(.N_CH(N), .MAX_PKT_WORDS(4)) dut (
        .CLK(CLK), .RST(RST), .din(din), .pkt_new(pkt_new), .pkt_end(pkt_end),
        .empty(empty), .rd_en(rd_en), .dout(dout), .wr_en(wr_en), .full(full),
        .active_ch(active_ch), .busy(busy), .err_sync(err_sync), .err_pkt_len(err_pkt_len)
    );

    logic [17:0] src[N][$];
    logic [15:0] expw[N][$];
    int          explen[N][$];
    logic [15:0] outq[$];
    int          wr_log[$];
    int          got_order[$], exp_order[$];
    logic [N-1:0] hide, pend;
    int n_cmp = 0, n_bad = 0;
    int cyc, first_rd, n_pops, held_rd, held_wr, rnd_full, rnd_hide, mptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic wq_t with_csum(input wq_t w);
        logic [31:0] s;
        wq_t r;
        s = 0;
        for (int k = 0; k < w.size(); k += 2)
            s += {(k + 1 < w.size()) ? w[k + 1] : 16'h0, w[k]};
        r = w;
        r.push_back(~s[15:0]);
        r.push_back(~s[31:16]);
        return r;
    endfunction

    function automatic int rr_next(input int p, input logic [N-1:0] pm);
        for (int k = 1; k <= N; k++) if (pm[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic srcs_empty();
        for (int i = 0; i < N; i++) if (src[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            empty[i] = src[i].size() == 0 || hide[i];
            if (src[i].size() != 0) begin
                din[16*i +: 16] = src[i][0][15:0];
                pkt_new[i]      = src[i][0][17];
                pkt_end[i]      = src[i][0][16];
            end else begin
                din[16*i +: 16] = 16'h0;
                pkt_new[i]      = 1'b0;
                pkt_end[i]      = 1'b0;
            end
        end
    endtask

    task automatic push_word(input int ch, input logic nw, input logic en, input logic [15:0] w);
        src[ch].push_back({nw, en, w});
        drive();
    endtask

    task automatic add_pkt(input int ch, input int n);
        logic [15:0] w;
        logic [3:0]  c;
        c = 4'(ch);
        for (int k = 0; k < n; k++) begin
            w = {c, 12'($urandom)};
            expw[ch].push_back(w);
            push_word(ch, k == 0, k == n - 1, w);
        end
        explen[ch].push_back(n);
    endtask

    task automatic step();
        logic [N-1:0] pops;
        @(negedge CLK);
        if (wr_en) begin
            outq.push_back(dout);
            wr_log.push_back(cyc);
        end
        if (full && |rd_en) held_rd++;
        if (full && wr_en) held_wr++;
        if (|rd_en && first_rd < 0) first_rd = cyc;
        pops = rd_en;
        @(posedge CLK);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (pops[i]) begin
                chk("pop_when_empty", hide[i] || src[i].size() == 0, 0);
                if (src[i].size() != 0) void'(src[i].pop_front());
                n_pops++;
            end
        end
        if (pops != 0) chk("one_pop_per_cycle", $countones(pops), 1);
        if (rnd_full > 0) full = $urandom_range(99) < rnd_full;
        if (rnd_hide > 0) for (int i = 0; i < N; i++) hide[i] = $urandom_range(99) < rnd_hide;
        drive();
    endtask

    task automatic drain(input int budget);
        int quiet;
        quiet = 0;
        for (int k = 0; k < budget && quiet < 4; k++) begin
            step();
            if (srcs_empty()) begin
                rnd_full = 0;
                full = 1'b0;
            end
            quiet = (busy || wr_en || !srcs_empty()) ? 0 : quiet + 1;
        end
        chk("drain_done", quiet >= 4, 1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        full = 1'b0;
        hide = '0;
        rnd_full = 0;
        rnd_hide = 0;
        for (int i = 0; i < N; i++) begin
            src[i].delete();
            expw[i].delete();
            explen[i].delete();
        end
        drive();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        outq.delete();
        wr_log.delete();
        got_order.delete();
        cyc = 0;
        first_rd = -1;
        n_pops = 0;
        held_rd = 0;
        held_wr = 0;
    endtask

    task automatic chk_stream(input string tag, input wq_t e);
        chk({tag, "_len"}, outq.size(), e.size());
        for (int k = 0; k < e.size() && k < outq.size(); k++) chk(tag, outq[k], e[k]);
    endtask

    task automatic parse();
        wq_t w, e;
        int ch, n;
        logic ok;
        while (outq.size() > 0) begin
            ch = int'(outq[0][15:12]);
            ok = ch < N && explen[ch].size() > 0;
            chk("pkt_owner", ok, 1);
            if (!ok) begin
                outq.delete();
                break;
            end
            n = explen[ch].pop_front();
            w.delete();
            repeat (n) w.push_back(expw[ch].pop_front());
            e = with_csum(w);
            chk("pkt_complete", outq.size() >= e.size(), 1);
            if (outq.size() < e.size()) begin
                outq.delete();
                break;
            end
            foreach (e[k]) chk("pkt_word", outq.pop_front(), e[k]);
            got_order.push_back(ch);
        end
    endtask

    task automatic chk_order();
        chk("order_len", got_order.size(), exp_order.size());
        for (int k = 0; k < got_order.size() && k < exp_order.size(); k++)
            chk("order_ch", got_order[k], exp_order[k]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        wq_t e;
        int left;
        do_reset();
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_dout", dout, 0);
        chk("rst_active_ch", active_ch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_sync", err_sync, 0);
        chk("rst_err_pkt_len", err_pkt_len, 0);

        // 4-word packet on ch0, exact stream and timing
        do_reset();
        for (int k = 0; k < 4; k++) push_word(0, k == 0, k == 3, 16'(k + 1));
        drain(100);
        e = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hFFFB, 16'hFFF9};
        chk_stream("t1_stream", e);
        chk("t1_wr_count", wr_log.size(), 6);
        if (wr_log.size() > 0) begin
            chk("t1_latency", wr_log[0], first_rd + 1);
            chk("t1_back_to_back", wr_log[wr_log.size() - 1] - wr_log[0], wr_log.size() - 1);
        end

        // single-word packet on ch2
        do_reset();
        push_word(2, 1'b1, 1'b1, 16'h1234);
        drain(100);
        e = '{16'h1234, 16'hEDCB, 16'hFFFF};
        chk_stream("t2_stream", e);
        chk("t2_active_ch", active_ch, 2);

        // round-robin order, then refill
        do_reset();
        add_pkt(0, 2);
        add_pkt(1, 2);
        add_pkt(3, 2);
        drain(200);
        parse();
        exp_order.delete();
        mptr = N - 1;
        pend = 4'b1011;
        repeat (3) begin
            mptr = rr_next(mptr, pend);
            exp_order.push_back(mptr);
            pend[mptr] = 1'b0;
        end
        chk_order();
        got_order.delete();
        exp_order.delete();
        add_pkt(0, 2);
        add_pkt(1, 2);
        drain(200);
        parse();
        pend = 4'b0011;
        repeat (2) begin
            mptr = rr_next(mptr, pend);
            exp_order.push_back(mptr);
            pend[mptr] = 1'b0;
        end
        chk_order();

        // full held for 5 cycles mid-packet
        do_reset();
        add_pkt(1, 4);
        for (int k = 0; k < 20 && n_pops < 2; k++) step();
        chk("t4_two_popped", n_pops, 2);
        full = 1'b1;
        repeat (5) step();
        full = 1'b0;
        chk("t4_rd_while_held", held_rd, 0);
        chk("t4_wr_while_full", held_wr, 0);
        drain(100);
        chk("t4_word_count", outq.size(), 6);
        parse();
        chk("t4_pkt_count", got_order.size(), 1);

        // sync error: stray word while idle
        do_reset();
        push_word(1, 1'b0, 1'b0, 16'hBEEF);
        repeat (3) step();
        chk("t5_err_sync", err_sync, 1);
        chk("t5_popped", src[1].size(), 0);
        chk("t5_nothing_written", outq.size(), 0);
        repeat (5) step();
        chk("t5_sticky", err_sync, 1);
        do_reset();
        chk("t5_cleared", err_sync, 0);

`ifdef OUTPKT_LEN_CHECK_EN
        // over-long packet cut at 4 words, tail discarded
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) expw[0].push_back(16'h0A00 + 16'(k));
            push_word(0, k == 0, k == 5, 16'h0A00 + 16'(k));
        end
        explen[0].push_back(4);
        drain(200);
        chk("t6_word_count", outq.size(), 6);
        parse();
        chk("t6_err_pkt_len", err_pkt_len, 1);
        chk("t6_err_sync", err_sync, 1);
        chk("t6_tail_dropped", src[0].size(), 0);
`endif

        // random packets, random stalls and bubbles
        for (int it = 0; it < 10; it++) begin
            do_reset();
            for (int c = 0; c < N; c++)
                repeat ($urandom_range(3)) add_pkt(c, $urandom_range(1, 4));
            rnd_full = 30;
            rnd_hide = 20;
            drain(1500);
            rnd_hide = 0;
            hide = '0;
            parse();
            left = 0;
            for (int c = 0; c < N; c++) left += explen[c].size();
            chk("rnd_all_emitted", left, 0);
            chk("rnd_err_sync", err_sync, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
